// File: rtl/vram_capture_arb.sv
// Shares one vram read port between the display, which always wins, and a line-capture
// engine that streams one line out through a small credit-managed FIFO.
module vram_capture_arb #(
  parameter int WIDTH      = 160,
  parameter int HEIGHT     = 144,
  parameter int RD_LAT     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clock25,
  input  logic        resetn,
  input  logic        disp_en,
  input  logic [7:0]  disp_x,
  input  logic [7:0]  disp_y,
  output logic        disp_valid,
  output logic [5:0]  disp_id,
  output logic [15:0] vram_addr,
  input  logic [5:0]  vram_rdata,
  input  logic        cap_start,
  input  logic        cap_abort,
  input  logic [7:0]  cap_line,
  output logic        cap_busy,
  output logic        cap_done,
  output logic        cap_valid,
  input  logic        cap_ready,
  output logic [5:0]  cap_id,
  output logic [7:0]  cap_x,
  output logic        cap_last
);
  localparam logic [7:0] W8 = 8'(WIDTH);
  localparam logic [7:0] H8 = 8'(HEIGHT);
  localparam int CW = $clog2(FIFO_DEPTH + RD_LAT + 1);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [1:0] {T_NONE, T_DISP, T_CAP} tag_e;
  typedef struct packed {
    tag_e       tag;
    logic [7:0] x;
  } slot_t;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_e;

  state_e             state_q, state_d;
  logic [7:0]         line_q, line_d, issue_x_q, issue_x_d;
  slot_t [RD_LAT-1:0] pipe_q, pipe_d;
  slot_t              slot_in, slot_out;
  logic [CW-1:0]      inflight, cnt_q;
  logic [PW-1:0]      wr_q, rd_q;
  logic [5:0]         fid_q [FIFO_DEPTH];
  logic [7:0]         fx_q  [FIFO_DEPTH];
  logic               cap_issue, push, pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++)
      if (pipe_q[i].tag == T_CAP) inflight = inflight + CW'(1);
  end

  // Credits count every CAP still in the read pipe, so the FIFO can never be overrun.
  assign cap_issue = !disp_en && !cap_abort && (state_q == S_RUN) && (issue_x_q < W8) &&
                     ((cnt_q + inflight) < CW'(FIFO_DEPTH));

  assign vram_addr = !resetn   ? '0 :
                     cap_issue ? {line_q, issue_x_q} : {disp_y, disp_x};

  always_comb begin
    slot_in = '{tag: T_NONE, x: issue_x_q};
    if (disp_en)        slot_in.tag = T_DISP;
    else if (cap_issue) slot_in.tag = T_CAP;
    pipe_d    = pipe_q;
    pipe_d[0] = slot_in;
    for (int i = 1; i < RD_LAT; i++) pipe_d[i] = pipe_q[i-1];
    if (cap_abort)
      for (int i = 0; i < RD_LAT; i++)
        if (pipe_d[i].tag == T_CAP) pipe_d[i].tag = T_NONE;
  end

  assign slot_out   = pipe_q[RD_LAT-1];
  assign disp_valid = (slot_out.tag == T_DISP);
  assign disp_id    = disp_valid ? vram_rdata : '0;

  assign cap_valid = (cnt_q != '0);
  assign pop       = cap_valid && cap_ready;
  assign push      = (slot_out.tag == T_CAP) && !cap_abort && ((cnt_q != CW'(FIFO_DEPTH)) || pop);
  assign cap_id    = cap_valid ? fid_q[rd_q] : '0;
  assign cap_x     = cap_valid ? fx_q[rd_q]  : '0;
  assign cap_last  = cap_valid && (fx_q[rd_q] == W8 - 8'd1);
  assign cap_busy  = (state_q != S_IDLE);

  always_comb begin
    state_d   = state_q;
    line_d    = line_q;
    issue_x_d = issue_x_q;
    cap_done  = 1'b0;
    case (state_q)
      S_IDLE:
        if (cap_start && (cap_line < H8)) begin
          state_d   = S_RUN;
          line_d    = cap_line;
          issue_x_d = '0;
        end
      S_RUN: begin
        if (cap_issue) issue_x_d = issue_x_q + 8'd1;
        if (issue_x_q == W8) state_d = S_DRAIN;
      end
      S_DRAIN:
        if ((cnt_q == '0) && (inflight == '0)) begin
          state_d  = S_IDLE;
          cap_done = 1'b1;
        end
      default: state_d = S_IDLE;
    endcase
    if (cap_abort) begin
      state_d  = S_IDLE;
      cap_done = 1'b0;
    end
  end

  always_ff @(posedge clock25 or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      line_q    <= '0;
      issue_x_q <= '0;
      for (int i = 0; i < RD_LAT; i++) pipe_q[i] <= '{tag: T_NONE, x: 8'd0};
    end else begin
      state_q   <= state_d;
      line_q    <= line_d;
      issue_x_q <= issue_x_d;
      pipe_q    <= pipe_d;
    end
  end

  always_ff @(posedge clock25 or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fid_q[i] <= '0;
        fx_q[i]  <= '0;
      end
    end else if (cap_abort) begin
      cnt_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
    end else begin
      if (push) begin
        fid_q[wr_q] <= vram_rdata;
        fx_q[wr_q]  <= slot_out.x;
        wr_q        <= ptr_inc(wr_q);
      end
      if (pop) rd_q <= ptr_inc(rd_q);
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: tb/tb_vram_capture_arb.sv
// Directed bench: a cycle table for arbitration/credit corners, then capture, stall,
// random-contention, abort and mid-capture reset sequences against a vram model.
module tb_vram_capture_arb;
  logic        clock25, resetn, disp_en, cap_start, cap_abort, cap_ready;
  logic [7:0]  disp_x, disp_y, cap_line, cap_x;
  logic        disp_valid, cap_busy, cap_done, cap_valid, cap_last;
  logic [5:0]  disp_id, vram_rdata, cap_id;
  logic [15:0] vram_addr;
  logic [5:0]  rp0 = '0, rp1 = '0;

  int checks = 0;
  int errors = 0;
  logic       dh_en [2];
  logic [7:0] dh_x  [2];
  logic [7:0] dh_y  [2];

  vram_capture_arb dut (
    .clock25(clock25), .resetn(resetn), .disp_en(disp_en), .disp_x(disp_x),
    .disp_y(disp_y), .disp_valid(disp_valid), .disp_id(disp_id), .vram_addr(vram_addr),
    .vram_rdata(vram_rdata), .cap_start(cap_start), .cap_abort(cap_abort),
    .cap_line(cap_line), .cap_busy(cap_busy), .cap_done(cap_done), .cap_valid(cap_valid),
    .cap_ready(cap_ready), .cap_id(cap_id), .cap_x(cap_x), .cap_last(cap_last)
  );

  initial clock25 = 1'b0;
  always #20 clock25 = ~clock25;

  function automatic logic [5:0] memf(input logic [7:0] y, input logic [7:0] x);
    return 6'((y * 7) + (x * 3));
  endfunction

  // Two-cycle vram read model.
  always @(posedge clock25) begin
    rp0 <= memf(vram_addr[15:8], vram_addr[7:0]);
    rp1 <= rp0;
  end
  assign vram_rdata = rp1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive_tick();
    @(posedge clock25);
    #1;
  endtask

  // Display reads must appear exactly two cycles after the request.
  task automatic disp_mon();
    chk("disp_valid", disp_valid, dh_en[1]);
    if (dh_en[1]) chk("disp_id", disp_id, memf(dh_y[1], dh_x[1]));
    dh_en[1] = dh_en[0]; dh_x[1] = dh_x[0]; dh_y[1] = dh_y[0];
    dh_en[0] = disp_en;  dh_x[0] = disp_x;  dh_y[0] = disp_y;
  endtask

  task automatic run_cap(input logic [7:0] line, input bit rnd, input int stall);
    int pops = 0, cyc = 0, done_cyc = -1, last_pop_cyc = -1, issues = 0;
    logic [7:0] exp_x = '0;
    while (cyc < 3000 && done_cyc < 0) begin
      drive_tick();
      cap_start = (cyc == 0);
      cap_line  = line;
      cap_abort = 1'b0;
      disp_en   = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      disp_x    = rnd ? 8'($urandom) : 8'hFF;
      disp_y    = rnd ? 8'($urandom) : 8'hFF;
      cap_ready = (cyc < stall) ? 1'b0 : (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
      #5;
      disp_mon();
      if (cyc < stall && vram_addr != 16'hFFFF) issues++;
      if (stall > 0 && cyc == stall - 1) begin
        chk("stall_issues", issues, 4);
        chk("stall_valid", cap_valid, 1'b1);
        chk("stall_x", cap_x, 8'd0);
        chk("stall_id", cap_id, memf(line, 8'd0));
      end
      if (cap_done) done_cyc = cyc;
      if (cap_valid && cap_ready) begin
        chk("cap_x", cap_x, exp_x);
        chk("cap_id", cap_id, memf(line, exp_x));
        chk("cap_last", cap_last, exp_x == 8'd159);
        if (exp_x == 8'd159) last_pop_cyc = cyc;
        exp_x++;
        pops++;
      end
      cyc++;
    end
    chk("cap_pops", pops, 160);
    chk("cap_done_timing", done_cyc, last_pop_cyc + 1);
    drive_tick();
    cap_start = 1'b0; disp_en = 1'b0;
    #5;
    disp_mon();
    chk("post_busy", cap_busy, 1'b0);
    chk("post_done", cap_done, 1'b0);
  endtask

  typedef struct {
    logic rstn; logic den; logic [7:0] dx; logic [7:0] dy;
    logic cs; logic ca; logic [7:0] cl; logic cr;
    logic [15:0] addr; logic dv; logic [5:0] did; logic busy; logic done;
    logic cv; logic [7:0] cx; logic [5:0] cid;
  } vec_t;
  vec_t tv [15];

  initial begin
    bit found;
    resetn = 1'b0; disp_en = 1'b0; disp_x = '0; disp_y = '0;
    cap_start = 1'b0; cap_abort = 1'b0; cap_line = '0; cap_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin dh_en[i] = 1'b0; dh_x[i] = '0; dh_y[i] = '0; end

    //          rstn  den   dx     dy     cs    ca    cl       cr     addr      dv    did    busy  done  cv    cx     cid
    tv[0]  = '{1'b0, 1'b1, 8'd3, 8'd4, 1'b0, 1'b0, 8'd0,   1'b0, 16'h0000, 1'b0, 6'd0,  1'b0, 1'b0, 1'b0, 8'd0, 6'd0};
    tv[1]  = '{1'b1, 1'b1, 8'd3, 8'd4, 1'b0, 1'b0, 8'd0,   1'b0, 16'h0403, 1'b0, 6'd0,  1'b0, 1'b0, 1'b0, 8'd0, 6'd0};
    tv[2]  = '{1'b1, 1'b1, 8'd5, 8'd4, 1'b0, 1'b0, 8'd0,   1'b0, 16'h0405, 1'b0, 6'd0,  1'b0, 1'b0, 1'b0, 8'd0, 6'd0};
    tv[3]  = '{1'b1, 1'b0, 8'd0, 8'd0, 1'b1, 1'b0, 8'd144, 1'b0, 16'h0000, 1'b1, 6'd37, 1'b0, 1'b0, 1'b0, 8'd0, 6'd0};
    tv[4]  = '{1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 8'd0,   1'b0, 16'h0000, 1'b1, 6'd43, 1'b0, 1'b0, 1'b0, 8'd0, 6'd0};
    tv[5]  = '{1'b1, 1'b0, 8'd0, 8'd0, 1'b1, 1'b0, 8'd10,  1'b0, 16'h0000, 1'b0, 6'd0,  1'b0, 1'b0, 1'b0, 8'd0, 6'd0};
    tv[6]  = '{1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 8'd0,   1'b0, 16'h0A00, 1'b0, 6'd0,  1'b1, 1'b0, 1'b0, 8'd0, 6'd0};
    tv[7]  = '{1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 8'd0,   1'b0, 16'h0A01, 1'b0, 6'd0,  1'b1, 1'b0, 1'b0, 8'd0, 6'd0};
    tv[8]  = '{1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 8'd0,   1'b0, 16'h0A02, 1'b0, 6'd0,  1'b1, 1'b0, 1'b0, 8'd0, 6'd0};
    tv[9]  = '{1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 8'd0,   1'b0, 16'h0A03, 1'b0, 6'd0,  1'b1, 1'b0, 1'b1, 8'd0, 6'd6};
    tv[10] = '{1'b1, 1'b1, 8'd7, 8'd9, 1'b0, 1'b0, 8'd0,   1'b0, 16'h0907, 1'b0, 6'd0,  1'b1, 1'b0, 1'b1, 8'd0, 6'd6};
    tv[11] = '{1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 8'd0,   1'b0, 16'h0000, 1'b0, 6'd0,  1'b1, 1'b0, 1'b1, 8'd0, 6'd6};
    tv[12] = '{1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 8'd0,   1'b0, 16'h0000, 1'b1, 6'd20, 1'b1, 1'b0, 1'b1, 8'd0, 6'd6};
    tv[13] = '{1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 1'b1, 8'd0,   1'b0, 16'h0000, 1'b0, 6'd0,  1'b1, 1'b0, 1'b1, 8'd0, 6'd6};
    tv[14] = '{1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 8'd0,   1'b0, 16'h0000, 1'b0, 6'd0,  1'b0, 1'b0, 1'b0, 8'd0, 6'd0};

    for (int i = 0; i < 15; i++) begin
      if (i > 0) drive_tick();
      resetn = tv[i].rstn; disp_en = tv[i].den; disp_x = tv[i].dx; disp_y = tv[i].dy;
      cap_start = tv[i].cs; cap_abort = tv[i].ca; cap_line = tv[i].cl; cap_ready = tv[i].cr;
      #5;
      chk($sformatf("v%0d_addr", i), vram_addr, tv[i].addr);
      chk($sformatf("v%0d_dvalid", i), disp_valid, tv[i].dv);
      chk($sformatf("v%0d_did", i), disp_id, tv[i].did);
      chk($sformatf("v%0d_busy", i), cap_busy, tv[i].busy);
      chk($sformatf("v%0d_done", i), cap_done, tv[i].done);
      chk($sformatf("v%0d_cvalid", i), cap_valid, tv[i].cv);
      chk($sformatf("v%0d_cx", i), cap_x, tv[i].cx);
      chk($sformatf("v%0d_cid", i), cap_id, tv[i].cid);
    end

    // Continuous display with a capture started underneath: no CAP address may appear.
    for (int i = 0; i < 160; i++) begin
      drive_tick();
      disp_en = 1'b1; disp_x = 8'(i); disp_y = 8'd5;
      cap_start = (i == 0); cap_line = 8'd10; cap_ready = 1'b1; cap_abort = 1'b0;
      #5;
      disp_mon();
      chk("disp_addr", vram_addr, {8'd5, 8'(i)});
    end
    drive_tick();
    disp_en = 1'b0; disp_x = 8'hFF; disp_y = 8'hFF; cap_start = 1'b0; cap_abort = 1'b1;
    #5; disp_mon();
    drive_tick();
    cap_abort = 1'b0;
    #5; disp_mon();
    chk("abort1_busy", cap_busy, 1'b0);

    run_cap(8'd10, 1'b0, 0);
    run_cap(8'd10, 1'b0, 20);
    run_cap(8'd143, 1'b1, 0);

    // Abort with reads in flight once x=80 has been issued.
    drive_tick();
    disp_en = 1'b0; disp_x = 8'hFF; disp_y = 8'hFF;
    cap_start = 1'b1; cap_line = 8'd20; cap_ready = 1'b1; cap_abort = 1'b0;
    #5; disp_mon();
    found = 1'b0;
    for (int c = 0; c < 400 && !found; c++) begin
      drive_tick();
      cap_start = 1'b0;
      #5; disp_mon();
      if (vram_addr == 16'h1450) found = 1'b1;
    end
    chk("abort_x80_seen", found, 1'b1);
    drive_tick();
    cap_abort = 1'b1;
    #5; disp_mon();
    chk("abort_pre_busy", cap_busy, 1'b1);
    chk("abort_pre_done", cap_done, 1'b0);
    drive_tick();
    cap_abort = 1'b0;
    #5; disp_mon();
    chk("abort_valid", cap_valid, 1'b0);
    chk("abort_busy", cap_busy, 1'b0);
    repeat (10) begin
      drive_tick();
      #5; disp_mon();
      chk("abort_no_done", cap_done, 1'b0);
      chk("abort_no_valid", cap_valid, 1'b0);
    end
    run_cap(8'd0, 1'b0, 0);

    // Reset pulse mid-capture with data waiting in the FIFO.
    drive_tick();
    cap_start = 1'b1; cap_line = 8'd50; cap_ready = 1'b0;
    #5; disp_mon();
    repeat (8) begin
      drive_tick();
      cap_start = 1'b0;
      #5; disp_mon();
    end
    drive_tick();
    #2;
    chk("rst_pre_busy", cap_busy, 1'b1);
    chk("rst_pre_valid", cap_valid, 1'b1);
    resetn = 1'b0;
    #1;
    chk("rst_addr", vram_addr, 16'h0000);
    chk("rst_dvalid", disp_valid, 1'b0);
    chk("rst_did", disp_id, 6'd0);
    chk("rst_busy", cap_busy, 1'b0);
    chk("rst_done", cap_done, 1'b0);
    chk("rst_cvalid", cap_valid, 1'b0);
    chk("rst_cid", cap_id, 6'd0);
    chk("rst_cx", cap_x, 8'd0);
    chk("rst_last", cap_last, 1'b0);
    drive_tick();
    #5; disp_mon();
    drive_tick();
    resetn = 1'b1; cap_ready = 1'b1;
    repeat (20) begin
      #5; disp_mon();
      chk("rel_done", cap_done, 1'b0);
      chk("rel_busy", cap_busy, 1'b0);
      chk("rel_valid", cap_valid, 1'b0);
      drive_tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/vram_capture_arb.md
VRAM_CAPTURE_ARB -- requirements
Module: vram_capture_arb

Interface
REQ-001 SHALL take parameters: WIDTH, default 160, pixels per line; HEIGHT, default 144, lines per frame; RD_LAT, default 2, vram read latency in cycles; FIFO_DEPTH, default 4, capture output FIFO entries.
REQ-002 SHALL have ports (name, direction, width, meaning):
- clock25 in 1: pixel-domain clock.
- resetn in 1: asynchronous, active-low reset.
- disp_en in 1: display needs a read this cycle.
- disp_x in 8: display pixel x.
- disp_y in 8: display pixel y.
- disp_valid out 1: display read data valid.
- disp_id out 6: display palette id.
- vram_addr out 16: read address {y,x} to vram port.
- vram_rdata in 6: vram read data.
- cap_start in 1: capture start pulse.
- cap_abort in 1: capture abort pulse.
- cap_line in 8: line to capture.
- cap_busy out 1: capture in progress.
- cap_done out 1: one-cycle completion pulse.
- cap_valid out 1: stream data valid.
- cap_ready in 1: stream consumer ready.
- cap_id out 6: captured palette id.
- cap_x out 8: captured pixel index.
- cap_last out 1: marks pixel WIDTH-1.
REQ-003 Reset resetn, asynchronous, active-low; clock clock25.

Function
REQ-004 Display SHALL have absolute priority: when disp_en=1, vram_addr={disp_y,disp_x} that cycle and the slot is tagged DISP.
REQ-005 When disp_en=0, state=RUN, issue_x<WIDTH and credits>0, vram_addr={line_q,issue_x}, slot tagged CAP, and issue_x SHALL increment.
REQ-006 Otherwise vram_addr SHALL hold {disp_y,disp_x} and the slot is tagged NONE.
REQ-007 Tags SHALL travel a RD_LAT-deep shift register. The tag leaving it qualifies vram_rdata:
- DISP -> disp_valid=1, disp_id=vram_rdata.
- CAP -> push {vram_rdata, pixel index} to FIFO.
- NONE -> disp_valid=0.
REQ-008 Display read latency SHALL be exactly RD_LAT cycles from disp_en to disp_valid, and SHALL never be stalled by capture.
REQ-009 credits = FIFO_DEPTH - (fifo_count + CAP tags in flight). A CAP issue SHALL never overflow the FIFO.
REQ-010 States: IDLE, RUN, DRAIN.
- IDLE: on cap_start with cap_line<HEIGHT, latch line_q, issue_x=0, go to RUN.
- IDLE: cap_start with cap_line>=HEIGHT is ignored.
- RUN: when issue_x reaches WIDTH, go to DRAIN.
- DRAIN: when the FIFO is empty, no CAP is in flight and the last pop has occurred, go to IDLE with cap_done=1 for one cycle.
REQ-011 cap_start in RUN or DRAIN SHALL be ignored.
REQ-012 cap_busy=1 in RUN and DRAIN.
REQ-013 Stream output:
- cap_valid = FIFO non-empty.
- A pop occurs on cap_valid and cap_ready.
- cap_id, cap_x and cap_last SHALL be stable while cap_valid=1 and cap_ready=0.
- Pixels SHALL be emitted in x order 0..WIDTH-1, exactly once each.
REQ-014 cap_last=1 exactly when cap_x=WIDTH-1.
REQ-015 cap_abort, any state: next state IDLE, FIFO flushed, CAP tags in flight converted to NONE, no cap_done. cap_abort takes precedence over a simultaneous cap_start.
REQ-016 issue_x is 8 bits. It compares against WIDTH and SHALL not wrap.
REQ-017 A simultaneous push and pop with the FIFO full or empty SHALL keep the count consistent, with no loss or duplication.

Reset
REQ-018 On resetn=0, outputs SHALL be:
- disp_valid=0, disp_id=0, vram_addr=0.
- cap_busy=0, cap_done=0, cap_valid=0, cap_id=0, cap_x=0, cap_last=0.
- state IDLE, FIFO empty, all tags NONE.
REQ-019 Reset asserted mid-capture SHALL discard everything, with no cap_done after release.

Verification
REQ-020 disp_en=1 continuously with disp_x=0..159, disp_y=5 -> disp_valid rises 2 cycles after the first disp_en, disp_id matches the model per pixel; cap_start meanwhile produces no CAP address.
REQ-021 disp_en=0, cap_start with cap_line=10, cap_ready=1 -> 160 pops, cap_x 0..159 with ids matching vram line 10, cap_last on x=159, cap_done 1 cycle after the final pop.
REQ-022 cap_ready=0 during capture -> exactly 4 CAP issues then stall, cap_valid held with cap_x=0 stable; cap_ready=1 resumes with no loss or duplication.
REQ-023 Random disp_en (50%) with random cap_ready during capture of line 143 -> all 160 pixels in order, display latency always 2.
REQ-024 cap_abort at x=80 with reads in flight -> cap_valid=0 next cycle, cap_busy=0, no cap_done; a subsequent cap_start with line 0 captures cleanly.
REQ-025 cap_start with cap_line=144 -> ignored, cap_busy stays 0; resetn pulse mid-RUN -> all outputs take their reset values immediately.
